// File: rtl/multdiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the RV64 execute stage.
// Fixed-latency multiply path and a radix-2 restoring divider with RISC-V M corner cases.
//
// state | meaning
// IDLE  | waiting for valid_i; latches op/operands on accept
// MUL   | multiply latency countdown
// DIV   | one restoring-divide iteration per cycle
// DONE  | done_o pulse, result_o valid
module multdiv_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] MULT_MUL    = 4'd0;
  localparam logic [3:0] MULT_MULH   = 4'd1;
  localparam logic [3:0] MULT_MULHSU = 4'd2;
  localparam logic [3:0] MULT_MULHU  = 4'd3;
  localparam logic [3:0] MULT_DIV    = 4'd4;
  localparam logic [3:0] MULT_DIVU   = 4'd5;
  localparam logic [3:0] MULT_REM    = 4'd6;
  localparam logic [3:0] MULT_REMU   = 4'd7;
  localparam logic [3:0] MULT_MULW   = 4'd8;

  logic [1:0]  state_q, state_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic [6:0]  div_cnt_q, div_cnt_d;
  logic [3:0]  op_q, op_d;
  logic [63:0] a_q, a_d;       // multiplicand, or dividend/quotient shift register
  logic [63:0] b_q, b_d;       // multiplier, or divisor
  logic [63:0] rem_q, rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] result_q, result_d;

  logic [3:0]         mop;
  logic [63:0]        ma, mb, mul_res;
  logic               a_sx, b_sx;
  logic signed [127:0] ax, bx, prod;
  logic [64:0]        rem_sh;
  logic               borrow;
  logic [63:0]        diff, rem_nx, quo_nx, q_fix, r_fix, div_res;
  logic               in_is_div, in_signed, in_is_quo;
  logic [63:0]        a_abs, b_abs;

  always_comb begin
    // The multiplier sees the live inputs in IDLE so MUL_LAT=1 can finish at the accept edge.
    mop  = (state_q == S_IDLE) ? op_i : op_q;
    ma   = (state_q == S_IDLE) ? a_i  : a_q;
    mb   = (state_q == S_IDLE) ? b_i  : b_q;
    a_sx = (mop == MULT_MULH) || (mop == MULT_MULHSU);
    b_sx = (mop == MULT_MULH);
    // Low 128 bits of the 65x65 extended product are all that any result needs.
    ax   = {{64{a_sx & ma[63]}}, ma};
    bx   = {{64{b_sx & mb[63]}}, mb};
    prod = ax * bx;
    case (mop)
      MULT_MUL:                            mul_res = prod[63:0];
      MULT_MULH, MULT_MULHSU, MULT_MULHU:  mul_res = prod[127:64];
      MULT_MULW:                           mul_res = {{32{prod[31]}}, prod[31:0]};
      default:                             mul_res = 64'd0;
    endcase

    rem_sh  = {rem_q, a_q[63]};
    borrow  = rem_sh < {1'b0, b_q};
    diff    = rem_sh[63:0] - b_q;
    rem_nx  = borrow ? rem_sh[63:0] : diff;
    quo_nx  = {a_q[62:0], ~borrow};
    q_fix   = q_neg_q ? -quo_nx : quo_nx;
    r_fix   = r_neg_q ? -rem_nx : rem_nx;
    div_res = ((op_q == MULT_DIV) || (op_q == MULT_DIVU)) ? q_fix : r_fix;

    in_is_div = (op_i == MULT_DIV) || (op_i == MULT_DIVU) || (op_i == MULT_REM) || (op_i == MULT_REMU);
    in_signed = (op_i == MULT_DIV) || (op_i == MULT_REM);
    in_is_quo = (op_i == MULT_DIV) || (op_i == MULT_DIVU);
    a_abs     = (in_signed && a_i[63]) ? -a_i : a_i;
    b_abs     = (in_signed && b_i[63]) ? -b_i : b_i;

    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    div_cnt_d = div_cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d = op_i;
          if (in_is_div) begin
            if (b_i == 64'd0) begin
              result_d = in_is_quo ? '1 : a_i;
              state_d  = S_DONE;
            end else if (in_signed && (a_i == 64'h8000_0000_0000_0000) && (b_i == '1)) begin
              result_d = in_is_quo ? a_i : 64'd0;
              state_d  = S_DONE;
            end else begin
              a_d       = a_abs;
              b_d       = b_abs;
              rem_d     = 64'd0;
              q_neg_d   = in_signed & (a_i[63] ^ b_i[63]);
              r_neg_d   = in_signed & a_i[63];
              div_cnt_d = 7'd64;
              state_d   = S_DIV;
            end
          end else begin
            a_d = a_i;
            b_d = b_i;
            if (MUL_LAT == 1) begin
              result_d = mul_res;
              state_d  = S_DONE;
            end else begin
              mul_cnt_d = 4'(MUL_LAT - 1);
              state_d   = S_MUL;
            end
          end
        end
      end
      S_MUL: begin
        if (mul_cnt_q <= 4'd1) begin
          mul_cnt_d = 4'd0;
          result_d  = mul_res;
          state_d   = S_DONE;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      S_DIV: begin
        a_d       = quo_nx;
        rem_d     = rem_nx;
        div_cnt_d = div_cnt_q - 7'd1;
        if (div_cnt_q == 7'd1) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d   = S_IDLE;
      mul_cnt_d = 4'd0;
      div_cnt_d = 7'd0;
      result_d  = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      mul_cnt_q <= 4'd0;
      div_cnt_q <= 7'd0;
      op_q      <= 4'd0;
      a_q       <= 64'd0;
      b_q       <= 64'd0;
      rem_q     <= 64'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      div_cnt_q <= div_cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: vector table plus flush/reset/back-to-back sequences,
// with expected results and completion cycles queued at issue and matched on done_o.
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [63:0] a_i = 64'd0;
  logic [63:0] b_i = 64'd0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o;
  logic [63:0] result_o;

  multdiv_ctrl #(.MUL_LAT(3)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  exp_t  sbq[$];
  vec_t  vecs[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string cur_name = "reset";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] res, input int due);
    exp_t e;
    e.res = res;
    e.due = due;
    sbq.push_back(e);
  endtask

  task automatic add(input string name, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] res, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Advances negedge by negedge until done_o; returns busy cycles seen before it.
  task automatic wait_done(input string name, output int busy_n);
    bit seen;
    seen   = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else if (busy_o) busy_n++;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done_o want done_o", name);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && done_o) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_unexpected_done: got done_o result %h want no done_o", cur_name, result_o);
      end else begin
        e = sbq.pop_front();
        check({cur_name, "_result"}, result_o, e.res);
        check({cur_name, "_done_cycle"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic do_op(input vec_t v);
    int busy_n;
    cur_name = v.name;
    op_i = v.op; a_i = v.a; b_i = v.b; valid_i = 1'b1;
    push_exp(v.res, cyc + v.lat);
    wait_done(v.name, busy_n);
    valid_i = 1'b0;
    check({v.name, "_busy_cycles"}, 64'(busy_n), 64'(v.lat - 1));
    @(negedge clk);
    check({v.name, "_done_pulse"}, 64'(done_o), 64'd0);
    check({v.name, "_result_held"}, result_o, v.res);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  initial begin
    int busy_n;
    logic [63:0] last_res;

    add("mulh",      4'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 3);
    add("mulhu",     4'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd2, 3);
    add("mulw",      4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    add("mul",       4'd0, 64'd6, 64'd7, 64'd42, 3);
    add("mulhsu",    4'd2, ONES, 64'd2, ONES, 3);
    add("illegal",   4'd9, 64'd6, 64'd7, 64'd0, 3);
    add("div",       4'd4, -64'd7, 64'd2, -64'd3, 65);
    add("rem",       4'd6, -64'd7, 64'd2, ONES, 65);
    add("divu",      4'd5, 64'd100, 64'd7, 64'd14, 65);
    add("remu",      4'd7, 64'd100, 64'd7, 64'd2, 65);
    add("div_negb",  4'd4, 64'd7, -64'd2, -64'd3, 65);
    add("rem_negb",  4'd6, 64'd7, -64'd2, 64'd1, 65);
    add("divu_big",  4'd5, 64'd5, ONES, 64'd0, 65);
    add("remu_big",  4'd7, 64'd5, ONES, 64'd5, 65);
    add("div_minn",  4'd4, MINN, 64'd1, MINN, 65);
    add("divu_zero", 4'd5, 64'd5, 64'd0, ONES, 1);
    add("rem_zero",  4'd6, 64'd5, 64'd0, 64'd5, 1);
    add("div_ovf",   4'd4, MINN, ONES, MINN, 1);
    add("rem_ovf",   4'd6, MINN, ONES, 64'd0, 1);

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);
    last_res = vecs[vecs.size() - 1].res;

    // Flush a divide mid-flight; a request presented alongside the flush must wait a cycle.
    cur_name = "flush";
    op_i = 4'd4; a_i = 64'd100; b_i = 64'd7; valid_i = 1'b1;
    @(posedge clk);
    repeat (30) @(negedge clk);
    flush_i = 1'b1;
    op_i = 4'd0; a_i = 64'd6; b_i = 64'd7;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_done", 64'(done_o), 64'd0);
    check("flush_result_kept", result_o, last_res);
    cur_name = "reissue_mul";
    push_exp(64'd42, cyc + 3);
    wait_done("reissue_mul", busy_n);
    valid_i = 1'b0;
    check("reissue_mul_busy_cycles", 64'(busy_n), 64'd2);
    @(negedge clk);

    // Reset in the middle of a divide.
    cur_name = "reset_mid";
    op_i = 4'd4; a_i = 64'd100; b_i = 64'd7; valid_i = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("reset_mid_busy", 64'(busy_o), 64'd0);
    check("reset_mid_done", 64'(done_o), 64'd0);
    check("reset_mid_result", result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Back-to-back multiplies with the request held high across the DONE cycle.
    cur_name = "b2b_first";
    op_i = 4'd0; a_i = 64'd3; b_i = 64'd4; valid_i = 1'b1;
    push_exp(64'd12, cyc + 3);
    wait_done("b2b_first", busy_n);
    cur_name = "b2b_second";
    a_i = 64'd5; b_i = 64'd5;
    push_exp(64'd25, cyc + 4);
    wait_done("b2b_second", busy_n);
    valid_i = 1'b0;
    check("b2b_second_busy_cycles", 64'(busy_n), 64'd2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
